// File: rtl/tone_symbol_assembler.sv
// Debounces per-analysis tone detections into symbols and frames START + 4 data tones
// (2 bits each, MSB first) into bytes delivered on a valid/ready handshake.
module tone_symbol_assembler #(
  parameter int unsigned STABLE_COUNT   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [2:0]  START_TONE     = 3'd7
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [2:0] tone_ident,
  input  logic       tone_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid_out,
  input  logic       byte_ready_in,
  output logic       frame_error_out,
  output logic       overrun_out,
  output logic       busy_out
);

  localparam int unsigned RUN_W = $clog2(STABLE_COUNT + 1);
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_COUNT);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, DATA} state_t;

  logic [2:0]       last_ident;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  logic             same_ident;
  logic             sym_hit;
  logic             sym_evt;
  logic [2:0]       sym_ident;

  state_t           state, state_next;
  logic [1:0]       sym_cnt, sym_cnt_next;
  logic [5:0]       shreg, shreg_next;
  logic [TO_W-1:0]  timeout_cnt, timeout_next;
  logic [1:0]       data_bits;
  logic [7:0]       done_byte;
  logic             byte_done;
  logic             frame_err;

  // A symbol fires only on the strobe that brings the run up to STABLE_COUNT;
  // a saturated run of the same ident stays silent.
  always_comb begin
    same_ident = (tone_ident == last_ident);
    run_next   = RUN_W'(1);
    if (same_ident) begin
      run_next = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
    end
    sym_hit = tone_valid && (tone_ident != 3'd0) && (run_next == RUN_MAX) &&
              !(same_ident && (run_cnt == RUN_MAX));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_ident <= '0;
      run_cnt    <= '0;
      sym_evt    <= 1'b0;
      sym_ident  <= '0;
    end else begin
      sym_evt <= sym_hit;
      if (sym_hit) begin
        sym_ident <= tone_ident;
      end
      if (tone_valid) begin
        last_ident <= tone_ident;
        run_cnt    <= run_next;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      sym_cnt     <= '0;
      shreg       <= '0;
      timeout_cnt <= '0;
    end else begin
      state       <= state_next;
      sym_cnt     <= sym_cnt_next;
      shreg       <= shreg_next;
      timeout_cnt <= timeout_next;
    end
  end

  // Only six bits are held: the fourth symbol completes the byte combinationally.
  always_comb begin
    state_next   = state;
    sym_cnt_next = sym_cnt;
    shreg_next   = shreg;
    timeout_next = timeout_cnt;
    byte_done    = 1'b0;
    frame_err    = 1'b0;
    data_bits    = 2'(sym_ident - 3'd1);
    done_byte    = {shreg, data_bits};
    unique case (state)
      IDLE: begin
        if (sym_evt && (sym_ident == START_TONE)) begin
          state_next   = DATA;
          sym_cnt_next = '0;
          shreg_next   = '0;
          timeout_next = '0;
        end
      end
      DATA: begin
        timeout_next = timeout_cnt + TO_W'(1);
        if (sym_evt) begin
          timeout_next = '0;
          if (sym_ident == START_TONE) begin
            frame_err    = 1'b1;
            sym_cnt_next = '0;
            shreg_next   = '0;
          end else if ((sym_ident >= 3'd1) && (sym_ident <= 3'd4)) begin
            if (sym_cnt == 2'd3) begin
              byte_done    = 1'b1;
              state_next   = IDLE;
              sym_cnt_next = '0;
            end else begin
              shreg_next   = {shreg[3:0], data_bits};
              sym_cnt_next = sym_cnt + 2'd1;
            end
          end else begin
            frame_err  = 1'b1;
            state_next = IDLE;
          end
        end else if (timeout_cnt == TO_MAX) begin
          frame_err    = 1'b1;
          state_next   = IDLE;
          timeout_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      byte_out        <= '0;
      byte_valid_out  <= 1'b0;
      frame_error_out <= 1'b0;
      overrun_out     <= 1'b0;
    end else begin
      frame_error_out <= frame_err;
      overrun_out     <= byte_done && byte_valid_out && !byte_ready_in;
      if (byte_done && (!byte_valid_out || byte_ready_in)) begin
        byte_out       <= done_byte;
        byte_valid_out <= 1'b1;
      end else if (byte_valid_out && byte_ready_in) begin
        byte_valid_out <= 1'b0;
      end
    end
  end

  assign busy_out = (state == DATA);

endmodule

// File: tb/tb_tone_symbol_assembler.sv
// Directed bench for tone_symbol_assembler: framing, debounce, errors, timeout, overrun, reset.
module tb_tone_symbol_assembler;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [2:0] tone_ident;
  logic       tone_valid;
  logic [7:0] byte_out;
  logic       byte_valid_out;
  logic       byte_ready_in;
  logic       frame_error_out;
  logic       overrun_out;
  logic       busy_out;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned n_err  = 0;
  int unsigned n_ovr  = 0;
  logic [7:0]  rx[$];
  int unsigned e0, o0;
  logic [7:0]  got_byte;

  tone_symbol_assembler #(
    .STABLE_COUNT  (3),
    .TIMEOUT_CYCLES(200),
    .START_TONE    (3'd7)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .tone_ident     (tone_ident),
    .tone_valid     (tone_valid),
    .byte_out       (byte_out),
    .byte_valid_out (byte_valid_out),
    .byte_ready_in  (byte_ready_in),
    .frame_error_out(frame_error_out),
    .overrun_out    (overrun_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (byte_valid_out && byte_ready_in) rx.push_back(byte_out);
    if (frame_error_out) n_err++;
    if (overrun_out) n_ovr++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic pulse(input logic [2:0] id);
    @(posedge clk_in);
    #1;
    tone_valid = 1'b1;
    tone_ident = id;
    @(posedge clk_in);
    #1;
    tone_valid = 1'b0;
  endtask

  task automatic tone(input logic [2:0] id, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      pulse(id);
      idle(6);
    end
  endtask

  // START, silence, then 4 data tones (ident = 2-bit digit + 1), MSB first.
  task automatic frame(input logic [7:0] b, input bit timed);
    logic [1:0] d;
    logic [2:0] id;
    tone(3'd7, 3);
    tone(3'd0, 1);
    for (int k = 0; k < 4; k++) begin
      d  = b[7-2*k -: 2];
      id = 3'({1'b0, d}) + 3'd1;
      if (k < 3) begin
        tone(id, 3);
        tone(3'd0, 1);
      end else begin
        tone(id, 2);
        pulse(id);
        if (timed) begin
          check_eq("valid_before_latency", 32'(byte_valid_out), 32'd0);
          idle(1);
          check_eq("valid_at_latency", 32'(byte_valid_out), 32'd1);
          check_eq("byte_at_latency", 32'(byte_out), 32'(b));
          idle(1);
          check_eq("valid_one_cycle", 32'(byte_valid_out), 32'd0);
          idle(4);
        end else begin
          idle(6);
        end
        tone(3'd0, 1);
      end
    end
  endtask

  initial begin
    rst_in        = 1'b1;
    tone_ident    = 3'd0;
    tone_valid    = 1'b0;
    byte_ready_in = 1'b1;
    idle(3);
    rst_in = 1'b0;
    idle(1);
    check_eq("reset_valid", 32'(byte_valid_out), 32'd0);
    check_eq("reset_byte", 32'(byte_out), 32'd0);
    check_eq("reset_busy", 32'(busy_out), 32'd0);
    check_eq("reset_pulses", 32'(n_err + n_ovr), 32'd0);

    // 1: basic frame 0x72 with exact output latency
    e0 = n_err;
    frame(8'h72, 1'b1);
    check_eq("t1_count", 32'(rx.size()), 32'd1);
    got_byte = (rx.size() > 0) ? rx.pop_front() : 8'hxx;
    check_eq("t1_byte", 32'(got_byte), 32'h72);
    check_eq("t1_no_error", n_err - e0, 32'd0);
    check_eq("t1_idle", 32'(busy_out), 32'd0);

    // 2: held data tone counts once
    rx.delete();
    e0 = n_err;
    tone(3'd7, 3);
    tone(3'd0, 1);
    check_eq("t2_busy", 32'(busy_out), 32'd1);
    tone(3'd2, 20);
    tone(3'd0, 1);
    tone(3'd4, 3);
    tone(3'd0, 1);
    tone(3'd1, 3);
    tone(3'd0, 1);
    check_eq("t2_no_early_byte", 32'(rx.size()), 32'd0);
    check_eq("t2_still_busy", 32'(busy_out), 32'd1);
    tone(3'd3, 3);
    check_eq("t2_count", 32'(rx.size()), 32'd1);
    got_byte = (rx.size() > 0) ? rx.pop_front() : 8'hxx;
    check_eq("t2_byte", 32'(got_byte), 32'h72);
    check_eq("t2_no_error", n_err - e0, 32'd0);

    // 3: invalid tone aborts
    tone(3'd0, 1);
    e0 = n_err;
    tone(3'd7, 3);
    tone(3'd0, 1);
    tone(3'd5, 3);
    check_eq("t3_error", n_err - e0, 32'd1);
    check_eq("t3_busy", 32'(busy_out), 32'd0);
    check_eq("t3_no_byte", 32'(rx.size()), 32'd0);

    // 4: timeout after one data symbol, then recovery
    tone(3'd0, 1);
    e0 = n_err;
    tone(3'd7, 3);
    tone(3'd0, 1);
    tone(3'd2, 3);
    idle(150);
    check_eq("t4_before_timeout_busy", 32'(busy_out), 32'd1);
    check_eq("t4_before_timeout_err", n_err - e0, 32'd0);
    idle(70);
    check_eq("t4_timeout_err", n_err - e0, 32'd1);
    check_eq("t4_timeout_idle", 32'(busy_out), 32'd0);
    tone(3'd0, 1);
    frame(8'h72, 1'b0);
    check_eq("t4_recover_count", 32'(rx.size()), 32'd1);
    got_byte = (rx.size() > 0) ? rx.pop_front() : 8'hxx;
    check_eq("t4_recover_byte", 32'(got_byte), 32'h72);

    // 5: overrun while output is blocked
    rx.delete();
    o0 = n_ovr;
    byte_ready_in = 1'b0;
    frame(8'h72, 1'b0);
    frame(8'h1B, 1'b0);
    check_eq("t5_valid_held", 32'(byte_valid_out), 32'd1);
    check_eq("t5_byte_held", 32'(byte_out), 32'h72);
    check_eq("t5_overrun", n_ovr - o0, 32'd1);
    check_eq("t5_no_transfer", 32'(rx.size()), 32'd0);
    byte_ready_in = 1'b1;
    idle(1);
    check_eq("t5_valid_fall", 32'(byte_valid_out), 32'd0);
    check_eq("t5_xfer_count", 32'(rx.size()), 32'd1);
    got_byte = (rx.size() > 0) ? rx.pop_front() : 8'hxx;
    check_eq("t5_xfer_byte", 32'(got_byte), 32'h72);

    // 6: reset mid-frame, then a clean frame
    e0 = n_err;
    o0 = n_ovr;
    tone(3'd7, 3);
    tone(3'd0, 1);
    tone(3'd2, 3);
    tone(3'd0, 1);
    tone(3'd4, 3);
    rst_in = 1'b1;
    idle(1);
    rst_in = 1'b0;
    check_eq("t6_busy", 32'(busy_out), 32'd0);
    check_eq("t6_valid", 32'(byte_valid_out), 32'd0);
    check_eq("t6_byte", 32'(byte_out), 32'd0);
    check_eq("t6_pulses", 32'({frame_error_out, overrun_out}), 32'd0);
    idle(3);
    check_eq("t6_no_error", (n_err - e0) + (n_ovr - o0), 32'd0);
    frame(8'h1B, 1'b1);
    check_eq("t6_count", 32'(rx.size()), 32'd1);
    got_byte = (rx.size() > 0) ? rx.pop_front() : 8'hxx;
    check_eq("t6_byte_after", 32'(got_byte), 32'h1B);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
